bullet_pool: RTL and testbench



---
 rtl/tank_pkg.sv | 42 ++++
 rtl/bullet_slot.sv | 79 +++++++
 rtl/bullet_pool.sv | 118 +++++++++++
 tb/tb_bullet_pool.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tank_pkg.sv
// Shared constants, bullet slot record and coordinate helpers for the tank game.
package tank_pkg;

    localparam int unsigned BULLETS_PER_TANK = 3;
    localparam int unsigned NUM_BULLETS      = 2 * BULLETS_PER_TANK;
    localparam int unsigned POS_W            = 10;
    localparam int unsigned VEL_W            = 4;
    localparam int unsigned AGE_W            = 10;

    localparam int X_MIN = 0;
    localparam int X_MAX = 639;
    localparam int Y_MIN = 0;
    localparam int Y_MAX = 479;

    localparam logic [POS_W-1:0] PARK_POS = 10'd1023;

    typedef struct packed {
        logic                    active;
        logic [POS_W-1:0]        x;
        logic [POS_W-1:0]        y;
        logic signed [VEL_W-1:0] vx;
        logic signed [VEL_W-1:0] vy;
        logic [AGE_W-1:0]        age;
    } bullet_t;

    // Parked slot: off-screen so it can never come within hit range of a tank.
    localparam bullet_t PARKED = '{active: 1'b0, x: PARK_POS, y: PARK_POS,
                                   vx: '0, vy: '0, age: '0};

    function automatic logic in_bounds(input logic signed [POS_W:0] v,
                                       input int lo, input int hi);
        return (int'(v) >= lo) && (int'(v) <= hi);
    endfunction

    function automatic logic [POS_W-1:0] clamp_pos(input logic signed [12:0] v,
                                                   input int lo, input int hi);
        if (int'(v) < lo) return POS_W'(lo);
        if (int'(v) > hi) return POS_W'(hi);
        return v[POS_W-1:0];
    endfunction

endpackage

// File: rtl/bullet_slot.sv
// One bullet slot: per-frame motion, wall handling, aging and spawn load.
// Wall behaviour selected by BULLET_BOUNCE_EN (bounce) or default (retire).
module bullet_slot
    import tank_pkg::*;
#(
    parameter int unsigned LIFETIME = 600
) (
    input  logic                    Clk,
    input  logic                    Reset,
    input  logic                    i_tick,
    input  logic                    i_clear,
    input  logic                    i_load,
    input  logic [POS_W-1:0]        i_ld_x,
    input  logic [POS_W-1:0]        i_ld_y,
    input  logic signed [VEL_W-1:0] i_ld_vx,
    input  logic signed [VEL_W-1:0] i_ld_vy,
    output bullet_t                 o_bullet,
    output logic                    o_free_c
);

    bullet_t               r_b;
    bullet_t               w_step;
    bullet_t               w_next;
    logic signed [POS_W:0] w_nx;
    logic signed [POS_W:0] w_ny;
    logic                  w_x_ok;
    logic                  w_y_ok;
    logic                  w_retire;

    // Motion and aging for one frame tick, before any spawn load.
    always_comb begin
        w_step   = r_b;
        w_retire = 1'b0;
        w_nx     = $signed({1'b0, r_b.x}) + (POS_W+1)'(r_b.vx);
        w_ny     = $signed({1'b0, r_b.y}) + (POS_W+1)'(r_b.vy);
        w_x_ok   = in_bounds(w_nx, X_MIN, X_MAX);
        w_y_ok   = in_bounds(w_ny, Y_MIN, Y_MAX);
        if (i_tick && r_b.active) begin
`ifdef BULLET_BOUNCE_EN
            if (w_x_ok) w_step.x  = w_nx[POS_W-1:0];
            else        w_step.vx = -r_b.vx;
            if (w_y_ok) w_step.y  = w_ny[POS_W-1:0];
            else        w_step.vy = -r_b.vy;
`else
            if (w_x_ok && w_y_ok) begin
                w_step.x = w_nx[POS_W-1:0];
                w_step.y = w_ny[POS_W-1:0];
            end else begin
                w_retire = 1'b1;
            end
`endif
            w_step.age = r_b.age + AGE_W'(1);
            if (r_b.age == AGE_W'(LIFETIME - 1)) w_retire = 1'b1;
            if (w_retire) w_step = PARKED;
        end
    end

    assign o_free_c = !w_step.active;

    always_comb begin
        w_next = w_step;
        if (i_load) begin
            w_next.active = 1'b1;
            w_next.x      = i_ld_x;
            w_next.y      = i_ld_y;
            w_next.vx     = i_ld_vx;
            w_next.vy     = i_ld_vy;
            w_next.age    = '0;
        end
    end

    always_ff @(posedge Clk) begin
        if (Reset || i_clear) r_b <= PARKED;
        else                  r_b <= w_next;
    end

    assign o_bullet = r_b;

endmodule

// File: rtl/bullet_pool.sv
// Six-slot bullet pool: fire edge detect, per-tank cooldown and slot allocation.
// Optional macro BULLET_BOUNCE_EN makes bullets bounce off walls instead of retiring.
module bullet_pool
    import tank_pkg::*;
#(
    parameter int unsigned LIFETIME   = 600,
    parameter int unsigned COOLDOWN   = 15,
    parameter int unsigned SPAWN_LEAD = 4
) (
    input  logic                               Clk,
    input  logic                               Reset,
    input  logic                               frame_tick,
    input  logic                               round_clear,
    input  logic                               fire1,
    input  logic                               fire2,
    input  logic [POS_W-1:0]                   t1x,
    input  logic [POS_W-1:0]                   t1y,
    input  logic [POS_W-1:0]                   t2x,
    input  logic [POS_W-1:0]                   t2y,
    input  logic signed [VEL_W-1:0]            t1vx,
    input  logic signed [VEL_W-1:0]            t1vy,
    input  logic signed [VEL_W-1:0]            t2vx,
    input  logic signed [VEL_W-1:0]            t2vy,
    output logic [NUM_BULLETS-1:0][POS_W-1:0]  bx,
    output logic [NUM_BULLETS-1:0][POS_W-1:0]  by,
    output logic [NUM_BULLETS-1:0]             bactive
);

    localparam int unsigned      COOL_W = (COOLDOWN > 0) ? $clog2(COOLDOWN + 1) : 1;
    localparam logic signed [12:0] LEAD = 13'(SPAWN_LEAD);

    logic [1:0]              w_fire;
    logic [1:0]              r_fire_q;
    logic [1:0]              r_pending;
    logic [1:0]              w_accept;
    logic [1:0]              w_spawn;
    logic [COOL_W-1:0]       r_cool [2];
    logic [POS_W-1:0]        w_tx [2];
    logic [POS_W-1:0]        w_ty [2];
    logic signed [VEL_W-1:0] w_tvx [2];
    logic signed [VEL_W-1:0] w_tvy [2];
    logic [POS_W-1:0]        w_sx [2];
    logic [POS_W-1:0]        w_sy [2];
    logic [NUM_BULLETS-1:0]  w_free;
    logic [NUM_BULLETS-1:0]  w_load;
    bullet_t                 w_bullet [NUM_BULLETS];

    assign w_fire = {fire2, fire1};

    // Spawn coordinates, accepted fire edges and lowest-free-slot selection per tank.
    always_comb begin
        w_tx[0]  = t1x;  w_ty[0]  = t1y;  w_tvx[0] = t1vx; w_tvy[0] = t1vy;
        w_tx[1]  = t2x;  w_ty[1]  = t2y;  w_tvx[1] = t2vx; w_tvy[1] = t2vy;
        w_load   = '0;
        w_spawn  = '0;
        w_accept = '0;
        for (int t = 0; t < 2; t++) begin
            w_sx[t] = clamp_pos($signed({3'b000, w_tx[t]}) + LEAD * 13'(w_tvx[t]), X_MIN, X_MAX);
            w_sy[t] = clamp_pos($signed({3'b000, w_ty[t]}) + LEAD * 13'(w_tvy[t]), Y_MIN, Y_MAX);
            w_accept[t] = w_fire[t] && !r_fire_q[t] && (r_cool[t] == '0);
            if (frame_tick && !round_clear && r_pending[t]) begin
                for (int i = 0; i < int'(BULLETS_PER_TANK); i++) begin
                    if (!w_spawn[t] && w_free[t * int'(BULLETS_PER_TANK) + i]) begin
                        w_load[t * int'(BULLETS_PER_TANK) + i] = 1'b1;
                        w_spawn[t] = 1'b1;
                    end
                end
            end
        end
    end

    // Fire history survives round_clear so a held button does not re-fire.
    always_ff @(posedge Clk) begin
        if (Reset) r_fire_q <= '0;
        else       r_fire_q <= w_fire;
    end

    always_ff @(posedge Clk) begin
        if (Reset || round_clear) begin
            r_pending <= '0;
            r_cool[0] <= '0;
            r_cool[1] <= '0;
        end else begin
            for (int t = 0; t < 2; t++) begin
                if (frame_tick) begin
                    r_pending[t] <= 1'b0;
                    if (w_spawn[t])             r_cool[t] <= COOL_W'(COOLDOWN);
                    else if (r_cool[t] != '0)   r_cool[t] <= r_cool[t] - COOL_W'(1);
                end else if (w_accept[t]) begin
                    r_pending[t] <= 1'b1;
                end
            end
        end
    end

    for (genvar g = 0; g < int'(NUM_BULLETS); g++) begin : g_slot
        localparam int unsigned TANK = g / BULLETS_PER_TANK;

        bullet_slot #(.LIFETIME(LIFETIME)) u_slot (
            .Clk      (Clk),
            .Reset    (Reset),
            .i_tick   (frame_tick),
            .i_clear  (round_clear),
            .i_load   (w_load[g]),
            .i_ld_x   (w_sx[TANK]),
            .i_ld_y   (w_sy[TANK]),
            .i_ld_vx  (w_tvx[TANK]),
            .i_ld_vy  (w_tvy[TANK]),
            .o_bullet (w_bullet[g]),
            .o_free_c (w_free[g])
        );

        assign bx[g]      = w_bullet[g].x;
        assign by[g]      = w_bullet[g].y;
        assign bactive[g] = w_bullet[g].active;
    end

endmodule

// File: tb/tb_bullet_pool.sv
// Directed bench for bullet_pool: spawn, motion, slot fill, walls, clear, lifetime.
// Wall expectations follow BULLET_BOUNCE_EN like the design.
module tb_bullet_pool;

    logic             Clk = 1'b0;
    logic             Reset;
    logic             frame_tick;
    logic             round_clear;
    logic             fire1;
    logic             fire2;
    logic [9:0]       t1x, t1y, t2x, t2y;
    logic signed [3:0] t1vx, t1vy, t2vx, t2vy;
    logic [5:0][9:0]  bx;
    logic [5:0][9:0]  by;
    logic [5:0]       bactive;

    int n_vec = 0;
    int n_err = 0;

    localparam logic [59:0] PARK6 = {6{10'd1023}};
    localparam logic [49:0] PARK5 = {5{10'd1023}};
    localparam logic [29:0] PARK3 = {3{10'd1023}};
    localparam logic [19:0] PARK2 = {2{10'd1023}};

    bullet_pool dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .frame_tick  (frame_tick),
        .round_clear (round_clear),
        .fire1       (fire1),
        .fire2       (fire2),
        .t1x         (t1x),
        .t1y         (t1y),
        .t2x         (t2x),
        .t2y         (t2y),
        .t1vx        (t1vx),
        .t1vy        (t1vy),
        .t2vx        (t2vx),
        .t2vy        (t2vy),
        .bx          (bx),
        .by          (by),
        .bactive     (bactive)
    );

    always #5 Clk = ~Clk;

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    task automatic tick();
        frame_tick = 1'b1;
        step();
        frame_tick = 1'b0;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    task automatic press1();
        fire1 = 1'b1;
        step();
        fire1 = 1'b0;
        step();
    endtask

    task automatic press2();
        fire2 = 1'b1;
        step();
        fire2 = 1'b0;
        step();
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    initial begin
        Reset = 1'b1; frame_tick = 1'b0; round_clear = 1'b0;
        fire1 = 1'b0; fire2 = 1'b0;
        t1x = '0; t1y = '0; t2x = '0; t2y = '0;
        t1vx = '0; t1vy = '0; t2vx = '0; t2vy = '0;
        repeat (2) step();
        Reset = 1'b0;
        step();
        chk("rst_active", 64'(bactive), 64'(0));
        chk("rst_bx", 64'(bx), 64'(PARK6));
        chk("rst_by", 64'(by), 64'(PARK6));

        ticks(5);
        chk("idle_active", 64'(bactive), 64'(0));
        chk("idle_bx", 64'(bx), 64'(PARK6));
        chk("idle_by", 64'(by), 64'(PARK6));

        // First spawn: 100 + 4*2 = 108, then +2 per tick
        t1x = 10'd100; t1y = 10'd100; t1vx = 4'sd2; t1vy = 4'sd0;
        press1();
        tick();                                  // T0
        chk("spawn_active", 64'(bactive), 64'(6'b000001));
        chk("spawn_x0", 64'(bx[0]), 64'(108));
        chk("spawn_y0", 64'(by[0]), 64'(100));
        chk("spawn_bx_rest", 64'(bx[5:1]), 64'(PARK5));
        chk("spawn_by_rest", 64'(by[5:1]), 64'(PARK5));
        tick();                                  // T1
        chk("move_x0", 64'(bx[0]), 64'(110));
        chk("move_y0", 64'(by[0]), 64'(100));
        chk("move_bx_rest", 64'(bx[5:1]), 64'(PARK5));

        // Fill tank-1 group once cooldown has expired
        ticks(14);                               // T2..T15
        t1x = 10'd200; t1y = 10'd200; t1vx = 4'sd0; t1vy = 4'sd1;
        press1();
        tick();                                  // T16
        chk("fill1_active", 64'(bactive), 64'(6'b000011));
        chk("fill1_x1", 64'(bx[1]), 64'(200));
        chk("fill1_y1", 64'(by[1]), 64'(204));
        chk("fill1_x0", 64'(bx[0]), 64'(140));
        ticks(15);                               // T17..T31
        press1();
        tick();                                  // T32
        chk("fill2_active", 64'(bactive), 64'(6'b000111));
        chk("fill2_x2", 64'(bx[2]), 64'(200));
        chk("fill2_y2", 64'(by[2]), 64'(204));
        chk("fill2_y1", 64'(by[1]), 64'(220));
        chk("fill2_x0", 64'(bx[0]), 64'(172));
        ticks(15);                               // T33..T47
        t2x = 10'd400; t2y = 10'd400; t2vx = 4'sd0; t2vy = 4'sd0;
        press1();
        press2();
        tick();                                  // T48: tank-1 dropped, tank-2 spawns
        chk("drop_active", 64'(bactive), 64'(6'b001111));
        chk("drop_y2", 64'(by[2]), 64'(220));
        chk("t2_x3", 64'(bx[3]), 64'(400));
        chk("t2_rest_bx", 64'(bx[5:4]), 64'(PARK2));

        // round_clear with frame_tick and pending requests
        press1();
        press2();
        round_clear = 1'b1;
        frame_tick  = 1'b1;
        step();
        round_clear = 1'b0;
        frame_tick  = 1'b0;
        chk("clr_active", 64'(bactive), 64'(0));
        chk("clr_bx", 64'(bx), 64'(PARK6));
        chk("clr_by", 64'(by), 64'(PARK6));
        tick();
        chk("clr_pending_gone", 64'(bactive), 64'(0));

        // Wall hit: spawn at 626 + 4*3 = 638; tank-2 fires at once (cooldown cleared)
        t1x = 10'd626; t1y = 10'd100; t1vx = 4'sd3; t1vy = 4'sd0;
        press1();
        press2();
        tick();
        chk("wall_spawn_active", 64'(bactive), 64'(6'b001001));
        chk("wall_spawn_x0", 64'(bx[0]), 64'(638));
        tick();
`ifdef BULLET_BOUNCE_EN
        chk("bounce_active", 64'(bactive), 64'(6'b001001));
        chk("bounce_x0", 64'(bx[0]), 64'(638));
        tick();
        chk("bounce_back_x0", 64'(bx[0]), 64'(635));
        chk("bounce_back_y0", 64'(by[0]), 64'(100));
`else
        chk("wall_active", 64'(bactive), 64'(6'b001000));
        chk("wall_x0", 64'(bx[0]), 64'(1023));
        chk("wall_y0", 64'(by[0]), 64'(1023));
`endif

        // Lifetime and tank-2 cooldown
        round_clear = 1'b1;
        step();
        round_clear = 1'b0;
        chk("clr2_active", 64'(bactive), 64'(0));
        t2x = 10'd300; t2y = 10'd300; t2vx = 4'sd0; t2vy = 4'sd0;
        press2();
        tick();                                  // L0
        chk("life_spawn_active", 64'(bactive), 64'(6'b001000));
        chk("life_spawn_x3", 64'(bx[3]), 64'(300));
        press2();                                // cooldown 15: ignored
        tick();                                  // L1
        chk("cool_ignore_a", 64'(bactive), 64'(6'b001000));
        ticks(13);                               // L2..L14
        press2();                                // cooldown 1: ignored
        tick();                                  // L15
        chk("cool_ignore_b", 64'(bactive), 64'(6'b001000));
        press2();                                // cooldown 0: accepted
        tick();                                  // L16
        chk("cool_accept", 64'(bactive), 64'(6'b011000));
        chk("cool_accept_x4", 64'(bx[4]), 64'(300));
        ticks(583);                              // L17..L599
        chk("life_599", 64'(bactive[3]), 64'(1));
        chk("life_599_x3", 64'(bx[3]), 64'(300));
        tick();                                  // L600
        chk("life_600", 64'(bactive), 64'(6'b010000));
        chk("life_600_x3", 64'(bx[3]), 64'(1023));
        chk("life_600_y3", 64'(by[3]), 64'(1023));
        chk("life_600_rest", 64'(bx[2:0]), 64'(PARK3));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
